// File: rtl/fir16_mac_pkg.sv
// Shared types and constants for the 16-tap Q1.15 FIR datapath stages.
package fir16_pkg;

  localparam int TAPS       = 16;
  localparam int DATA_W     = 16;
  localparam int COEFF_W    = 16;
  localparam int ACC_W      = 36;
  localparam int FRAC_SHIFT = 15;
  localparam int IDX_W      = $clog2(TAPS);

  typedef logic signed [DATA_W-1:0]  sample_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam sample_t Q15_MAX = 16'sh7FFF;
  localparam sample_t Q15_MIN = 16'sh8000;

endpackage

// File: rtl/fir16_mac_if.sv
// Sample-in / result-out valid-ready streams of the FIR MAC stage.
interface fir16_mac_if;
  import fir16_pkg::*;

  sample_t in_data;
  logic    in_valid;
  logic    in_ready;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/fir16_mac_round_sat.sv
// Accumulator to Q1.15 conversion: round-half-up by FRAC_SHIFT, then clamp.
module fir16_round_sat
  import fir16_pkg::*;
(
  input  acc_t    acc_i,
  output sample_t data_o
);

  localparam acc_t HALF = acc_t'(1) <<< (FRAC_SHIFT - 1);

  acc_t rounded;

  always_comb begin
    rounded = (acc_i + HALF) >>> FRAC_SHIFT;
    if (rounded > acc_t'(Q15_MAX)) begin
      data_o = Q15_MAX;
    end else if (rounded < acc_t'(Q15_MIN)) begin
      data_o = Q15_MIN;
    end else begin
      data_o = rounded[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fir16_mac.sv
// Time-multiplexed 16-tap FIR multiply-accumulate, one tap per clock.
// Define FIR16_MAC_SYMMETRIC_EN to fold symmetric taps through a pre-adder.
module fir16_mac
  import fir16_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TAPS*COEFF_W-1:0] coeff_flat,
  fir16_mac_if.slave              stream
);

`ifdef FIR16_MAC_SYMMETRIC_EN
  localparam int ITERS = TAPS / 2;
`else
  localparam int ITERS = TAPS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERS - 1);

  state_t           state_q, state_d;
  sample_t          taps_q [TAPS];
  acc_t             acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  sample_t          outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic             shiftEn;
  coeff_t           coeffSel;
  acc_t             prodExt;
  acc_t             sum;
  sample_t          roundedSum;

  assign coeffSel = coeff_t'(coeff_flat[idx_q*COEFF_W +: COEFF_W]);

`ifdef FIR16_MAC_SYMMETRIC_EN
  logic [IDX_W-1:0]               idxMirror;
  logic signed [DATA_W:0]         preSum;
  logic signed [DATA_W+COEFF_W:0] product;

  // Mirror taps share a coefficient, so add them before the single multiplier.
  assign idxMirror = IDX_W'(TAPS - 1) - idx_q;
  assign preSum    = (DATA_W+1)'(taps_q[idx_q]) + (DATA_W+1)'(taps_q[idxMirror]);
  assign product   = preSum * coeffSel;
`else
  logic signed [DATA_W+COEFF_W-1:0] product;

  assign product = taps_q[idx_q] * coeffSel;
`endif

  assign prodExt = acc_t'(product);
  assign sum     = acc_q + prodExt;

  fir16_round_sat u_roundSat (
    .acc_i  (sum),
    .data_o (roundedSum)
  );

  assign stream.out_data  = outData_q;
  assign stream.out_valid = outValid_q;

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    idx_d           = idx_q;
    outData_d       = outData_q;
    outValid_d      = outValid_q;
    shiftEn         = 1'b0;
    stream.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          shiftEn = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          outData_d  = roundedSum;
          outValid_d = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        // A consumed result frees the slot, so a waiting sample can enter on the same edge.
        stream.in_ready = stream.out_ready;
        if (stream.out_ready) begin
          outValid_d = 1'b0;
          if (stream.in_valid) begin
            shiftEn = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = MAC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      if (shiftEn) begin
        taps_q[0] <= stream.in_data;
        for (int k = 1; k < TAPS; k++) begin
          taps_q[k] <= taps_q[k-1];
        end
      end
    end
  end

endmodule
